// File: rtl/pingpong_pkg.sv
// Shared types for the ping-pong multichannel buffer: writer state and drop-counter sizing.
package pingpong_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } wr_state_e;

  localparam int DROP_W = 16;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sp_ram_bank.sv
// Single-port RAM bank with synchronous read; one frame per word.
module sp_ram_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pingpong_mc_buffer.sv
// Two-bank ping-pong frame buffer: writer fills one bank while the reader owns the other,
// with stall-or-discard overrun handling and per-channel sample reads.
module pingpong_mc_buffer
  import pingpong_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 256,
  parameter int OVERWRITE = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [CHANNELS*WIDTH-1:0]   frame_i,
  input  logic                        frame_valid_i,
  input  logic                        rd_en_i,
  input  logic [$clog2(DEPTH)-1:0]    rd_addr_i,
  input  logic [2:0]                  rd_ch_i,
  input  logic                        rd_release_i,
  input  logic                        ovr_clr_i,
  output logic [WIDTH-1:0]            rd_data_o,
  output logic                        rd_valid_o,
  output logic                        buffer_ready_o,
  output logic                        rd_bank_o,
  output logic                        rd_held_o,
  output logic [$clog2(DEPTH):0]      fill_level_o,
  output logic                        overrun_o,
  output logic [DROP_W-1:0]           drop_cnt_o
);

  localparam int AW      = $clog2(DEPTH);
  localparam int FW      = AW + 1;
  localparam int FRAME_W = CHANNELS * WIDTH;

  wr_state_e                        state;
  logic                             wr_bank;
  logic [FW-1:0]                    fill_level;
  logic                             rd_bank_q;
  logic [2:0]                       rd_ch_q;
  logic [1:0][FRAME_W-1:0]          bank_q;
  logic [CHANNELS-1:0][WIDTH-1:0]   rd_frame;

  logic wr_fire, complete, rel_ok, handoff, discard, stall_go, drop;

  // A release arriving with a completing write is honoured first, so it becomes a normal handoff.
  always_comb begin
    wr_fire  = (state == FILL) && frame_valid_i;
    complete = wr_fire && (fill_level[AW-1:0] == AW'(DEPTH-1));
    rel_ok   = rd_release_i && rd_held_o;
    handoff  = (complete && (!rd_held_o || rel_ok)) || ((state == STALL) && rel_ok);
    discard  = complete && rd_held_o && !rel_ok && (OVERWRITE != 0);
    stall_go = complete && rd_held_o && !rel_ok && (OVERWRITE == 0);
    drop     = ((state == STALL) && frame_valid_i) || discard;
  end

  // The writer bank takes the write address; the other bank serves the reader.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic sel_wr;
    assign sel_wr = (wr_bank == 1'(b));
    sp_ram_bank #(.WIDTH(FRAME_W), .DEPTH(DEPTH)) u_ram (
      .clk   (clk_i),
      .we    (wr_fire && sel_wr),
      .addr  (sel_wr ? fill_level[AW-1:0] : rd_addr_i),
      .wdata (frame_i),
      .rdata (bank_q[b])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= FILL;
      wr_bank        <= 1'b0;
      fill_level     <= '0;
      rd_held_o      <= 1'b0;
      rd_bank_o      <= 1'b0;
      buffer_ready_o <= 1'b0;
      overrun_o      <= 1'b0;
      drop_cnt_o     <= '0;
    end else begin
      buffer_ready_o <= handoff;
      if (handoff) begin
        state      <= FILL;
        rd_bank_o  <= wr_bank;
        rd_held_o  <= 1'b1;
        wr_bank    <= ~wr_bank;
        fill_level <= '0;
      end else begin
        if (rel_ok) rd_held_o <= 1'b0;
        if (stall_go) begin
          state      <= STALL;
          fill_level <= FW'(DEPTH);
        end else if (discard) begin
          fill_level <= '0;
        end else if (wr_fire) begin
          fill_level <= fill_level + 1'b1;
        end
      end
      // A fresh drop wins over a clear in the same cycle.
      if (drop)           overrun_o <= 1'b1;
      else if (ovr_clr_i) overrun_o <= 1'b0;
      if (drop) drop_cnt_o <= sat_inc(drop_cnt_o);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_o <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_ch_q    <= '0;
    end else begin
      rd_valid_o <= rd_en_i && rd_held_o;
      rd_bank_q  <= rd_bank_o;
      rd_ch_q    <= rd_ch_i;
    end
  end

  // Out-of-range channels fall through to zero; data is forced to zero when not valid.
  always_comb begin
    rd_frame  = bank_q[rd_bank_q];
    rd_data_o = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (rd_valid_o && (rd_ch_q == 3'(c))) rd_data_o = rd_frame[c];
  end

  assign fill_level_o = fill_level;

endmodule

// File: tb/tb_pingpong_mc_buffer.sv
// Bench: two buffers (stall and overwrite modes) share random/directed stimulus and are
// compared every cycle against a frame-level reference model, plus literal spot checks.
module tb_pingpong_mc_buffer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] frame;
  logic        fv, en, rel, clr;
  logic [1:0]  addr;
  logic [2:0]  ch;

  logic [15:0] rd_data [2];
  logic        rd_valid[2];
  logic        ready   [2];
  logic        rbank   [2];
  logic        held    [2];
  logic [2:0]  fill    [2];
  logic        ovr     [2];
  logic [15:0] drops   [2];

  always #5 clk = ~clk;

  pingpong_mc_buffer #(.WIDTH(16), .CHANNELS(2), .DEPTH(D), .OVERWRITE(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .frame_i(frame), .frame_valid_i(fv), .rd_en_i(en),
    .rd_addr_i(addr), .rd_ch_i(ch), .rd_release_i(rel), .ovr_clr_i(clr),
    .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]), .buffer_ready_o(ready[0]),
    .rd_bank_o(rbank[0]), .rd_held_o(held[0]), .fill_level_o(fill[0]),
    .overrun_o(ovr[0]), .drop_cnt_o(drops[0]));

  pingpong_mc_buffer #(.WIDTH(16), .CHANNELS(2), .DEPTH(D), .OVERWRITE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .frame_i(frame), .frame_valid_i(fv), .rd_en_i(en),
    .rd_addr_i(addr), .rd_ch_i(ch), .rd_release_i(rel), .ovr_clr_i(clr),
    .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]), .buffer_ready_o(ready[1]),
    .rd_bank_o(rbank[1]), .rd_held_o(held[1]), .fill_level_o(fill[1]),
    .overrun_o(ovr[1]), .drop_cnt_o(drops[1]));

  typedef struct {
    bit stalled; bit wbank; int level; bit held; bit rbank;
    bit ovr; int drops; bit ready; bit rvalid; int rdata;
  } mdl_t;

  mdl_t        md [2];
  logic [31:0] mem[2][2][D];
  int          n_cmp = 0, n_err = 0;
  bit          chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Frame-level reference: one call per clock edge, mode m selects stall (0) or discard (1).
  task automatic model_step(input int m);
    mdl_t s; bit r, hand, drop; logic [31:0] w;
    s = md[m]; r = rel && s.held; hand = 0; drop = 0;
    s.ready  = 0;
    s.rvalid = en && s.held;
    w = mem[m][s.rbank][addr];
    s.rdata = !s.rvalid ? 0 : (ch == 0) ? int'(w[15:0]) : (ch == 1) ? int'(w[31:16]) : 0;
    if (s.stalled) begin
      drop = fv; hand = r;
    end else if (fv) begin
      mem[m][s.wbank][s.level] = frame;
      if (s.level == D - 1) begin
        if (!s.held || r) hand = 1;
        else if (m == 0) begin s.stalled = 1; s.level = D; end
        else begin s.level = 0; drop = 1; end
      end else s.level++;
    end
    if (hand) begin
      s.rbank = s.wbank; s.held = 1; s.ready = 1; s.wbank = !s.wbank; s.level = 0; s.stalled = 0;
    end else if (r) s.held = 0;
    if (drop) s.ovr = 1; else if (clr) s.ovr = 0;
    if (drop && s.drops < 65535) s.drops++;
    md[m] = s;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int m = 0; m < 2; m++)
      if (!rst_n) md[m] = '{default: 0};
      else model_step(m);
  end

  initial forever begin
    @(negedge clk);
    if (chk_on)
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("d%0d.rd_valid", m), 32'(rd_valid[m]), 32'(md[m].rvalid));
        chk($sformatf("d%0d.rd_data", m),  32'(rd_data[m]),  md[m].rdata);
        chk($sformatf("d%0d.ready", m),    32'(ready[m]),    32'(md[m].ready));
        chk($sformatf("d%0d.held", m),     32'(held[m]),     32'(md[m].held));
        chk($sformatf("d%0d.rd_bank", m),  32'(rbank[m]),    32'(md[m].rbank));
        chk($sformatf("d%0d.fill", m),     32'(fill[m]),     md[m].level);
        chk($sformatf("d%0d.overrun", m),  32'(ovr[m]),      32'(md[m].ovr));
        chk($sformatf("d%0d.drop_cnt", m), 32'(drops[m]),    md[m].drops);
      end
  end

  function automatic logic [31:0] fr(input int k);
    return {16'(k + 1), 16'(k)};
  endfunction

  task automatic idle();
    fv = 0; en = 0; rel = 0; clr = 0; frame = '0; addr = '0; ch = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1; idle();
  endtask

  task automatic wr(input logic [31:0] f);
    fv = 1; frame = f; cyc();
  endtask

  task automatic all_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk({tag, ".held"},  32'(held[m]),  0);
      chk({tag, ".bank"},  32'(rbank[m]), 0);
      chk({tag, ".fill"},  32'(fill[m]),  0);
      chk({tag, ".ready"}, 32'(ready[m]), 0);
      chk({tag, ".ovr"},   32'(ovr[m]),   0);
      chk({tag, ".drops"}, 32'(drops[m]), 0);
      chk({tag, ".valid"}, 32'(rd_valid[m]), 0);
      chk({tag, ".data"},  32'(rd_data[m]), 0);
    end
  endtask

  initial begin
    idle();
    @(posedge clk); chk_on = 1; #1;
    @(posedge clk); #1;
    all_zero("reset");
    rst_n = 1;

    // first bank completes and is handed over; then channel reads
    for (int k = 0; k < 4; k++) begin
      wr(fr(k));
      if (k == 1) chk("lit.fill2", 32'(fill[0]), 2);
    end
    chk("lit.s1.ready", 32'(ready[0]), 1);
    chk("lit.s1.bank",  32'(rbank[0]), 0);
    chk("lit.s1.held",  32'(held[1]),  1);
    en = 1; addr = 2; ch = 1; cyc();
    chk("lit.s1.valid", 32'(rd_valid[0]), 1);
    chk("lit.s1.data",  32'(rd_data[0]),  32'h0003);
    en = 1; addr = 2; ch = 5; cyc();
    chk("lit.ch5.valid", 32'(rd_valid[1]), 1);
    chk("lit.ch5.data",  32'(rd_data[1]),  0);

    // second completion while bank 0 is held, then extra frames
    for (int k = 4; k < 8; k++) wr(fr(k));
    chk("lit.s2.stall_fill", 32'(fill[0]),  4);
    chk("lit.s2.ow_drops",   32'(drops[1]), 1);
    chk("lit.s2.ow_fill",    32'(fill[1]),  0);
    chk("lit.s2.ow_bank",    32'(rbank[1]), 0);
    chk("lit.s2.ow_ovr",     32'(ovr[1]),   1);
    for (int k = 8; k < 11; k++) wr(fr(k));
    chk("lit.s2.drops", 32'(drops[0]), 3);
    chk("lit.s2.ovr",   32'(ovr[0]),   1);
    chk("lit.s2.ow_drops_after", 32'(drops[1]), 1);
    rel = 1; cyc();
    chk("lit.s2.rel_ready", 32'(ready[0]), 1);
    chk("lit.s2.rel_bank",  32'(rbank[0]), 1);
    chk("lit.s2.rel_fill",  32'(fill[0]),  0);
    en = 1; addr = 3; ch = 0; cyc();
    chk("lit.s2.rd_bank1", 32'(rd_data[0]), 7);
    clr = 1; cyc();
    chk("lit.clr.ovr",   32'(ovr[0]),   0);
    chk("lit.clr.drops", 32'(drops[0]), 3);

    // release coinciding with the completing write
    for (int k = 0; k < 3; k++) wr(fr(20 + k));
    rel = 1; wr(fr(23));
    chk("lit.s4.ready", 32'(ready[0]), 1);
    chk("lit.s4.bank",  32'(rbank[0]), 0);
    chk("lit.s4.ovr",   32'(ovr[0]),   0);

    // clear coinciding with a drop keeps the flag set
    for (int k = 0; k < 4; k++) wr(fr(50 + k));
    chk("lit.s5.ovr_pre", 32'(ovr[0]), 0);
    fv = 1; clr = 1; frame = fr(60); cyc();
    chk("lit.s5.ovr",   32'(ovr[0]),   1);
    chk("lit.s5.drops", 32'(drops[0]), 4);

    // read with nothing held
    rel = 1; cyc();
    rel = 1; cyc();
    chk("lit.nohold.held", 32'(held[0]), 0);
    en = 1; addr = 0; ch = 0; cyc();
    chk("lit.nohold.valid", 32'(rd_valid[0]), 0);

    // asynchronous reset mid-fill
    wr(fr(30)); wr(fr(31));
    chk("lit.s6.fill2", 32'(fill[0]), 2);
    rst_n = 0; #1;
    all_zero("async_rst");
    @(posedge clk); #1; rst_n = 1;
    for (int k = 0; k < 4; k++) wr(fr(40 + k));
    chk("lit.s6.ready", 32'(ready[0]), 1);
    chk("lit.s6.bank",  32'(rbank[0]), 0);
    en = 1; addr = 1; ch = 1; cyc();
    chk("lit.s6.data", 32'(rd_data[0]), 32'h002A);

    // randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      fv    = ($urandom % 3) != 0;
      frame = $urandom;
      en    = $urandom % 2;
      addr  = 2'($urandom % 4);
      ch    = 3'($urandom % 8);
      rel   = ($urandom % 12) == 0;
      clr   = ($urandom % 24) == 0;
      if (($urandom % 1500) == 0) begin
        rst_n = 0; #2; rst_n = 1;
      end
      cyc();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pingpong_mc_buffer.md
PINGPONG_MC_BUFFER -- requirements
Module: pingpong_mc_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bits per channel sample.
REQ-002 SHALL have parameter CHANNELS, default 2, channels per frame (1..8).
REQ-003 SHALL have parameter DEPTH, default 256, frames per bank (power of two, >=4).
REQ-004 SHALL have parameter OVERWRITE, default 0, overrun mode (0 = stall and drop input, 1 = discard completed bank).
REQ-005 SHALL have ports:
- clk_i, input, 1: the single clock.
- rst_ni, input, 1: asynchronous active-low reset.
- frame_i, input, CHANNELS*WIDTH: one frame; channel 0 in the LSBs.
- frame_valid_i, input, 1: one-cycle strobe qualifying frame_i.
- rd_en_i, input, 1: read request.
- rd_addr_i, input, $clog2(DEPTH): frame index in the read bank.
- rd_ch_i, input, 3: channel select.
- rd_release_i, input, 1: reader frees the held bank.
- ovr_clr_i, input, 1: clears overrun_o.
- rd_data_o, output, WIDTH: read sample.
- rd_valid_o, output, 1: rd_data_o valid.
- buffer_ready_o, output, 1: one-cycle pulse when a bank is handed to the reader.
- rd_bank_o, output, 1: index of the held bank.
- rd_held_o, output, 1: reader owns a bank.
- fill_level_o, output, $clog2(DEPTH)+1: frames in the write bank.
- overrun_o, output, 1: sticky overrun flag.
- drop_cnt_o, output, 16: saturating dropped-event count.

Function
REQ-006 SHALL hold two banks of DEPTH words, each CHANNELS*WIDTH wide; the writer and the reader never access the same bank.
REQ-007 SHALL write frame_i to the write bank at address fill_level on each frame_valid_i while in state FILL, then increment fill_level.
REQ-008 SHALL complete a bank when the write lands at address DEPTH-1.
REQ-009 On completion with rd_held_o=0, SHALL in the next cycle:
- set rd_bank_o to the completed bank and rd_held_o=1;
- pulse buffer_ready_o;
- toggle the write bank;
- reset fill_level to 0.
REQ-010 On completion with rd_held_o=1 and OVERWRITE=0, SHALL enter state STALL.
- Every frame_valid_i in STALL is dropped and increments drop_cnt_o.
- overrun_o is set on the first drop.
REQ-011 In STALL, rd_release_i SHALL hand the stalled full bank to the reader next cycle (buffer_ready_o pulse) and return the writer to FILL at address 0 of the freed bank.
REQ-012 On completion with rd_held_o=1 and OVERWRITE=1, SHALL discard the completed bank: fill_level returns to 0 in the same bank, overrun_o is set, drop_cnt_o increments by 1; STALL is never entered.
REQ-013 rd_release_i together with a completing write SHALL be treated as release-first: normal handoff, no overrun.
REQ-014 rd_release_i with rd_held_o=0 SHALL be ignored.
REQ-015 rd_en_i with rd_held_o=1 SHALL produce rd_valid_o=1 one cycle later with rd_data_o = channel rd_ch_i of frame rd_addr_i.
REQ-016 rd_ch_i>=CHANNELS SHALL return rd_data_o=0 with rd_valid_o=1.
REQ-017 rd_en_i with rd_held_o=0 SHALL be ignored (rd_valid_o stays 0).
REQ-018 drop_cnt_o SHALL saturate at 16'hFFFF.
REQ-019 ovr_clr_i SHALL clear overrun_o only; drop_cnt_o clears only on reset.
REQ-020 ovr_clr_i together with a new drop SHALL leave overrun_o=1.
REQ-021 fill_level_o SHALL read DEPTH only while in STALL.

Reset
REQ-022 SHALL reset asynchronously on rst_ni low to:
- state FILL, write bank 0, fill_level 0;
- rd_held_o=0, rd_bank_o=0;
- all outputs 0.
REQ-023 Reset mid-fill or mid-read SHALL discard bank contents logically; RAM contents need not clear.

Structure
REQ-024 SHALL place the writer-state enum (FILL, STALL) and the drop counter width constant in shared package pingpong_pkg.
REQ-025 SHALL instantiate each bank as sub-module sp_ram_bank (single-port, synchronous read, parameters WIDTH and DEPTH), two instances.

Verification
REQ-026 SHALL cover the following directed scenarios, with WIDTH=16, CHANNELS=2, DEPTH=4:
- Four frames 0x0001_0000..0x0004_0003 -> buffer_ready_o pulse, rd_bank_o=0, rd_held_o=1; read addr 2, ch 1 -> rd_data_o=0x0003 one cycle later.
- OVERWRITE=0: hold bank 0, write 4 more frames, then 3 extra frames -> STALL, drop_cnt_o=3, overrun_o=1; rd_release_i -> buffer_ready_o pulse, rd_bank_o=1.
- OVERWRITE=1, same stimulus as the previous scenario -> no STALL, drop_cnt_o=1 after the second completion, fill_level_o=0, rd_bank_o stays 0.
- rd_release_i in the same cycle as the 4th write -> handoff, overrun_o=0.
- rd_ch_i=5 -> rd_data_o=0, rd_valid_o=1; rd_en_i with rd_held_o=0 -> rd_valid_o=0.
- rst_ni low after 2 writes -> all outputs 0 immediately; after release, the next 4 frames complete bank 0.
